// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 integer register file and its benches.
// Index constants are plain ints; users size them to their own index width.
package msrv32_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
endpackage

// File: rtl/msrv32_rf_bypass.sv
// Per-port read selector: x0 reads zero, a same-cycle committing write is
// forwarded, otherwise the stored array word is returned.
module msrv32_rf_bypass
    import msrv32_pkg::REG_ZERO;
#(
    parameter int XLEN = msrv32_pkg::XLEN,
    parameter int AW   = msrv32_pkg::AW
) (
    input  logic [AW-1:0]   addr,
    input  logic [AW-1:0]   wr_addr,
    input  logic            we_eff,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] arr_data,
    output logic [XLEN-1:0] data
);
    always_comb begin
        data = arr_data;
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
        end else if (we_eff && (addr == wr_addr)) begin
            data = wr_data;
        end
    end
endmodule

// File: rtl/msrv32_reg_block_wb.sv
// Integer register file at the writeback end: one write port with flush and
// x0 suppression, two combinational read ports with same-cycle bypass.
module msrv32_reg_block_wb
    import msrv32_pkg::REG_ZERO;
#(
    parameter int XLEN  = msrv32_pkg::XLEN,
    parameter int NREGS = msrv32_pkg::NREGS,
    parameter int AW    = msrv32_pkg::AW
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic [AW-1:0]   rs_1_addr_in,
    input  logic [AW-1:0]   rs_2_addr_in,
    input  logic [AW-1:0]   rd_addr_reg_in,
    input  logic            wr_en_reg_in,
    input  logic            flush_in,
    input  logic [XLEN-1:0] rd_in,
    output logic [XLEN-1:0] rs_1_out,
    output logic [XLEN-1:0] rs_2_out,
    output logic            wr_commit_out,
    output logic [15:0]     wr_count_out
);
    logic [XLEN-1:0] regs_reg [NREGS];
    logic            wr_commit_reg;
    logic [15:0]     wr_count_reg;
    logic            we_eff;

    // Reset is deliberately left out of we_eff: the bypass still forwards
    // during reset, only the array and counters are gated by it.
    assign we_eff = wr_en_reg_in & ~flush_in & (rd_addr_reg_in != AW'(REG_ZERO));

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!ms_riscv32_mp_rst_in) begin
                regs_reg[i] <= '0;
            end else if (we_eff && (rd_addr_reg_in == AW'(i))) begin
                regs_reg[i] <= rd_in;
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            wr_commit_reg <= 1'b0;
            wr_count_reg  <= '0;
        end else begin
            wr_commit_reg <= we_eff;
            if (we_eff) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
        end
    end

    assign wr_commit_out = wr_commit_reg;
    assign wr_count_out  = wr_count_reg;

    logic [AW-1:0]   port_addr [2];
    logic [XLEN-1:0] port_data [2];

    assign port_addr[0] = rs_1_addr_in;
    assign port_addr[1] = rs_2_addr_in;

    for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
        msrv32_rf_bypass #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_bypass (
            .addr     (port_addr[gi]),
            .wr_addr  (rd_addr_reg_in),
            .we_eff   (we_eff),
            .wr_data  (rd_in),
            .arr_data (regs_reg[port_addr[gi]]),
            .data     (port_data[gi])
        );
    end

    assign rs_1_out = port_data[0];
    assign rs_2_out = port_data[1];
endmodule
